// File: rtl/stoch_mult_array.sv
// N-channel stochastic multiplier: shared LFSR-driven SNGs feed per-channel AND/XNOR
// combiners whose ones-counts over one full LFSR period form the products.
module stoch_mult_array #(
    parameter int          N      = 2,
    parameter int          W      = 8,
    parameter logic [7:0]  SEED_A = 8'h01,
    parameter logic [7:0]  SEED_B = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [N*W-1:0]   op_a,
    input  logic [N*W-1:0]   op_b,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [N*W-1:0]   result
);

    // Tap masks select the bits XORed into bit 0 for each supported width.
    localparam logic [7:0]   TAPS8 = (W == 4) ? 8'h0C :
                                     (W == 5) ? 8'h14 :
                                     (W == 6) ? 8'h30 :
                                     (W == 7) ? 8'h60 : 8'hB8;
    localparam logic [W-1:0] TAPS       = TAPS8[W-1:0];
    localparam logic [W-1:0] SEED_A_W   = SEED_A[W-1:0];
    localparam logic [W-1:0] SEED_B_W   = SEED_B[W-1:0];
    localparam logic [W-1:0] LAST_CYCLE = {{(W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     lfsr_a_q, lfsr_b_q;
    logic [W-1:0]     cycle_q;
    logic [N*W-1:0]   op_a_q, op_b_q;
    logic             mode_q;
    logic [N*W-1:0]   acc_q;
    logic [W-1:0]     r_b;
    logic [N-1:0]     p;
    logic             start_ok;

    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = acc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (cycle_q == LAST_CYCLE) state_d = DONE;
            DONE: begin
                if (start) begin
                    state_d = RUN;
                end else if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // B's random value is bit-reversed so its streams are not shifted copies of A's.
    always_comb begin
        r_b = '0;
        p   = '0;
        for (int i = 0; i < W; i++) begin
            r_b[i] = lfsr_b_q[W-1-i];
        end
        for (int k = 0; k < N; k++) begin
            if (mode_q) begin
                p[k] = ~((op_a_q[k*W +: W] >= lfsr_a_q) ^ (op_b_q[k*W +: W] >= r_b));
            end else begin
                p[k] = (op_a_q[k*W +: W] >= lfsr_a_q) & (op_b_q[k*W +: W] >= r_b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_a_q <= SEED_A_W;
            lfsr_b_q <= SEED_B_W;
            cycle_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            mode_q   <= 1'b0;
            acc_q    <= '0;
        end else if (start_ok) begin
            lfsr_a_q <= SEED_A_W;
            lfsr_b_q <= SEED_B_W;
            cycle_q  <= '0;
            op_a_q   <= op_a;
            op_b_q   <= op_b;
            mode_q   <= mode;
            acc_q    <= '0;
        end else if (state_q == RUN) begin
            lfsr_a_q <= {lfsr_a_q[W-2:0], ^(lfsr_a_q & TAPS)};
            lfsr_b_q <= {lfsr_b_q[W-2:0], ^(lfsr_b_q & TAPS)};
            cycle_q  <= cycle_q + 1'b1;
            for (int k = 0; k < N; k++) begin
                acc_q[k*W +: W] <= acc_q[k*W +: W] + {{(W-1){1'b0}}, p[k]};
            end
        end
    end

endmodule

// File: tb/tb_stoch_mult_array.sv
// Directed bench for stoch_mult_array with a queue scoreboard checked whenever done rises.
module tb_stoch_mult_array;

    localparam int N = 2;
    localparam int W = 8;
    localparam int L = 255;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           mode;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic           ack;
    logic           busy;
    logic           done;
    logic [N*W-1:0] result;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic [N*W-1:0] res;
        string          name;
    } exp_t;

    exp_t exp_q[$];
    logic done_prev = 1'b0;

    stoch_mult_array #(.N(N), .W(W), .SEED_A(8'h01), .SEED_B(8'hA5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .op_a   (op_a),
        .op_b   (op_b),
        .ack    (ack),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Independent reference: x^8+x^6+x^5+x^4+1 Fibonacci LFSRs stepped one sample at a time.
    function automatic int model_count(input int a, input int b, input bit m);
        logic [7:0] la;
        logic [7:0] lb;
        logic [7:0] rb;
        int         cnt;
        bit         ba, bb;
        la  = 8'h01;
        lb  = 8'hA5;
        cnt = 0;
        for (int t = 0; t < L; t++) begin
            for (int i = 0; i < 8; i++) rb[i] = lb[7-i];
            ba = (a >= int'(la));
            bb = (b >= int'(rb));
            if (m) cnt += (ba == bb) ? 1 : 0;
            else   cnt += (ba && bb) ? 1 : 0;
            la = {la[6:0], la[7] ^ la[5] ^ la[4] ^ la[3]};
            lb = {lb[6:0], lb[7] ^ lb[5] ^ lb[4] ^ lb[3]};
        end
        return cnt;
    endfunction

    task automatic applyStimulus(input bit m, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                 input bit do_ack, input bit push, input logic [N*W-1:0] exp_res,
                                 input string name);
        exp_t e;
        mode  = m;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        ack   = do_ack;
        if (push) begin
            e.res  = exp_res;
            e.name = name;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic wait_done(input int already, output int cycles);
        cycles = already;
        while (!done && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!done) checkOutput("done_timeout", 32'(cycles), 32'(L));
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    // Monitor: each rising edge of done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'(result), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput({e.name, "_ch0"}, 32'(result[W-1:0]), 32'(e.res[W-1:0]));
                checkOutput({e.name, "_ch1"}, 32'(result[2*W-1:W]), 32'(e.res[2*W-1:W]));
            end
        end
        done_prev <= done;
    end

    initial begin
        int cyc;
        int stat;
        stat  = model_count(128, 128, 1'b0);
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        op_a  = '0;
        op_b  = '0;
        ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle_hold", {30'd0, busy, done} | 32'(result), 32'd0);

        applyStimulus(1'b0, {8'd0, 8'd255}, {8'd100, 8'd100}, 1'b0, 1'b1, {8'd0, 8'd100}, "unipolar");
        checkOutput("run_busy", 32'(busy), 32'd1);
        checkOutput("run_done", 32'(done), 32'd0);
        wait_done(0, cyc);
        checkOutput("unipolar_latency", 32'(cyc), 32'(L));
        checkOutput("unipolar_busy_end", 32'(busy), 32'd0);

        do_ack();
        checkOutput("ack_done", 32'(done), 32'd0);
        checkOutput("ack_busy", 32'(busy), 32'd0);
        checkOutput("ack_result_held", 32'(result), 32'({8'd0, 8'd100}));

        applyStimulus(1'b1, {8'd0, 8'd255}, {8'd37, 8'd37}, 1'b0, 1'b1, {8'd218, 8'd37}, "bipolar");
        wait_done(0, cyc);
        checkOutput("bipolar_latency", 32'(cyc), 32'(L));
        do_ack();

        applyStimulus(1'b0, {8'd128, 8'd128}, {8'd128, 8'd128}, 1'b0, 1'b1,
                      {8'(stat), 8'(stat)}, "stat");
        wait_done(0, cyc);
        checkOutput("stat_range", 32'((int'(result[W-1:0]) >= 52 && int'(result[W-1:0]) <= 76) ? 1 : 0), 32'd1);

        applyStimulus(1'b0, {8'd128, 8'd128}, {8'd128, 8'd128}, 1'b1, 1'b1,
                      {8'(stat), 8'(stat)}, "stat_repeat");
        checkOutput("start_ack_busy", 32'(busy), 32'd1);
        checkOutput("start_ack_done", 32'(done), 32'd0);
        checkOutput("start_ack_clear", 32'(result), 32'd0);
        wait_done(0, cyc);
        checkOutput("stat_repeat_latency", 32'(cyc), 32'(L));
        do_ack();

        // Mid-run start, ack and operand changes must not disturb the run.
        applyStimulus(1'b0, {8'd0, 8'd255}, {8'd7, 8'd200}, 1'b0, 1'b1, {8'd0, 8'd200}, "ignore_start");
        repeat (49) @(posedge clk);
        #1;
        start = 1'b1;
        mode  = 1'b1;
        op_a  = '0;
        op_b  = '1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        checkOutput("ack_in_run_busy", 32'(busy), 32'd1);
        wait_done(60, cyc);
        checkOutput("ignore_start_latency", 32'(cyc), 32'(L));
        do_ack();

        applyStimulus(1'b1, {8'd0, 8'd255}, {8'd37, 8'd37}, 1'b0, 1'b0, '0, "aborted");
        repeat (99) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_result", 32'(result), 32'd0);

        applyStimulus(1'b1, {8'd0, 8'd255}, {8'd37, 8'd37}, 1'b0, 1'b1, {8'd218, 8'd37}, "after_reset");
        wait_done(0, cyc);
        checkOutput("after_reset_latency", 32'(cyc), 32'(L));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/stoch_mult_array.md
Name: stoch_mult_array

Overview:
- Parametrised successor to the single stochastic multiplier in the Tiny Tapeout top level.
- N independent channels each multiply two W-bit unsigned operands by stochastic bitstream computing:
  - LFSR-driven stochastic number generators (SNGs) convert each operand to a bitstream;
  - an AND (unipolar) or XNOR (bipolar) gate combines the two streams;
  - a ones-counter accumulates the result over one full LFSR period.
- Sits behind the tt_um wrapper, which maps its operand/result buses onto ui/uio/uo pins.

Parameters:
- N, 2: number of channels (1..4).
- W, 8: operand/result width and LFSR width (4..8). Stream length L = 2^W - 1.
- SEED_A, 8'h01: LFSR_A reload value (low W bits used; must be nonzero).
- SEED_B, 8'hA5: LFSR_B reload value (low W bits used; must be nonzero).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin a run. Ignored unless the block is IDLE or DONE.
- mode  in  1  combine mode: 0 = unipolar (AND), 1 = bipolar (XNOR). Sampled with start.
- op_a  in  N*W  channel k operand A in bits [k*W +: W]. Sampled with start.
- op_b  in  N*W  channel k operand B in bits [k*W +: W]. Sampled with start.
- ack  in  1  clears done (DONE -> IDLE).
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE; result is valid while done is high.
- result  out  N*W  channel k ones-count in bits [k*W +: W].

Behaviour:
- Reset (rst_n low at an edge) forces:
  - state = IDLE; busy = 0; done = 0; result = 0;
  - both LFSRs loaded with their seeds; cycle counter cleared; operand and mode registers cleared.
  - Reset overrides everything, including during RUN; a partial count is discarded.
- LFSRs: Fibonacci, shift left, feedback into bit 0 = XOR of the tap bits. Taps are fixed per W:
  - W=4: x^4+x^3+1
  - W=5: x^5+x^3+1
  - W=6: x^6+x^5+1
  - W=7: x^7+x^6+1
  - W=8: x^8+x^6+x^5+x^4+1
  - Each LFSR visits all 2^W - 1 nonzero states in one period.
- Random values:
  - rA = LFSR_A state.
  - rB = bit-reverse of LFSR_B state (decorrelates the B streams from the A streams).
  - Both LFSRs are shared by all channels.
- SNG per channel: bitA = (a >= rA), bitB = (b >= rB). Over one period, the A stream has exactly a ones; the B stream has exactly b ones.
- Combine: unipolar p = bitA & bitB; bipolar p = ~(bitA ^ bitB).
- State machine:
  - IDLE --start--> RUN.
  - RUN --(cycle counter == L-1)--> DONE.
  - DONE --ack--> IDLE.
  - DONE --start--> RUN. start takes priority if start and ack are high in the same cycle.
- On an accepted start edge:
  - latch op_a, op_b and mode;
  - reload both LFSRs with their seeds;
  - clear the cycle counter and all result counters;
  - done drops to 0 and busy rises at the same edge.
- Each RUN edge:
  - result[k] += p[k], computed from the current LFSR states and latched operands;
  - both LFSRs advance; the cycle counter increments.
- Latency: exactly L RUN edges.
  - If start is sampled at edge e0, done is high after edge eL and busy low after edge eL.
  - W=8 gives 255 cycles.
- Result width:
  - The maximum count is L = 2^W - 1, so W bits never overflow; no saturation logic is needed.
  - Bipolar interpretation (value = 2*count/L - 1) is done in software.
- Input changes outside start edges:
  - start during RUN is ignored; the run continues unaffected.
  - ack outside DONE is ignored.
  - op_a, op_b and mode changes during RUN have no effect.
- result holds its value in DONE and IDLE until the next accepted start.
- Runs are fully deterministic: identical inputs give identical results.

Test Plan:
- Reset then idle: rst_n low for 2 cycles -> busy=0, done=0, result=0. No change while start=0.
- Exact unipolar, W=8, N=2, mode=0:
  - ch0 a=255, b=100; ch1 a=0, b=100.
  - Expect done exactly 255 cycles after start, result ch0=100, ch1=0.
- Exact bipolar, mode=1:
  - ch0 a=255, b=37; ch1 a=0, b=37.
  - Expect ch0=37, ch1=218 (255-37).
- Statistical product, mode=0, a=128, b=128:
  - Result matches a bit-accurate reference model of both LFSRs.
  - Result is within 64±12.
  - A repeat run with the same inputs gives an identical result.
- Handshake:
  - start pulsed at cycle 50 of a run -> ignored; done still at cycle 255.
  - In DONE, start and ack high together -> new run begins and result clears.
  - ack alone -> IDLE with result held.
- Reset mid-run: rst_n low at cycle 100 of a run -> next edge gives busy=0, result=0.
  - A following start gives the full 255-cycle run with correct results.
